spi_reg_ctrl: RTL and testbench

- Byte-level command sequencer between the SPI slave byte engine and the blink/config logic.
- Decodes the MOSI byte stream into register reads/writes on a small register file.
- Exports the register contents as a flat bus for the LED blink logic.
- Preloads the MISO transmit byte for read transactions.

---
 rtl/spi_reg_pkg.sv | 24 ++
 rtl/spi_cs_sync.sv | 32 +++
 rtl/spi_reg_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller.
// SPI_REG_CTRL_AUTOINC_EN selects post-increment addressing across a frame.
package spi_reg_pkg;

   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned CMD_RW_BIT = 7;

   localparam logic [7:0] DEF_ID_VALUE  = 8'hA5;
   localparam logic [7:0] DEF_OOR_VALUE = 8'hFF;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(0);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR,
      ST_RD
   } state_e;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select with edge detection.
// Idles high so an undriven or resetting CSn never looks like a frame start.
module spi_cs_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_cs_n,
   output logic o_cs_n,
   output logic o_cs_fall,
   output logic o_cs_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_cs_n;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_cs_n    = r_sync;
   assign o_cs_fall = r_prev & ~r_sync;
   assign o_cs_rise = ~r_prev & r_sync;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Byte-level command sequencer: decodes {rw, addr} + data bytes into register file accesses.
// Define SPI_REG_CTRL_AUTOINC_EN to post-increment the address after every data byte.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int unsigned NUM_REGS  = 8,
   parameter logic [7:0]  ID_VALUE  = DEF_ID_VALUE,
   parameter logic [7:0]  OOR_VALUE = DEF_OOR_VALUE
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_spi_cs_n,
   input  logic                  i_rx_done,
   input  logic [7:0]            i_rx_data,
   output logic                  o_tx_load,
   output logic [7:0]            o_tx_data,
   output logic [8*NUM_REGS-1:0] o_regs,
   output logic                  o_wr_strobe,
   output logic [ADDR_W-1:0]     o_wr_addr,
   output logic                  o_busy
);

   state_e              r_state, w_state_d;
   logic [ADDR_W-1:0]   r_addr, w_addr_d;
   logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_d;
   logic [7:0]          r_tx_data, w_tx_data_d;
   logic                r_tx_load, w_tx_load_d;
   logic                r_wr_strobe, w_wr_strobe_d;
   logic                w_wr_en;
   logic [8*NUM_REGS-1:8] r_regs;

   logic w_cs_n;
   logic w_cs_fall;
   logic w_cs_rise;

   spi_cs_sync u_cs_sync (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_cs_n    (i_spi_cs_n),
      .o_cs_n    (w_cs_n),
      .o_cs_fall (w_cs_fall),
      .o_cs_rise (w_cs_rise)
   );

   function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0]   a,
                                          input logic [8*NUM_REGS-1:0] regs);
      if (int'(a) >= NUM_REGS) rd_byte = OOR_VALUE;
      else                     rd_byte = regs[8*int'(a) +: 8];
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wr_addr   <= '0;
         r_tx_data   <= 8'h00;
         r_tx_load   <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_regs      <= '0;
      end else begin
         r_state     <= w_state_d;
         r_addr      <= w_addr_d;
         r_wr_addr   <= w_wr_addr_d;
         r_tx_data   <= w_tx_data_d;
         r_tx_load   <= w_tx_load_d;
         r_wr_strobe <= w_wr_strobe_d;
         if (w_wr_en) r_regs[8*int'(r_addr) +: 8] <= i_rx_data;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_addr_d      = r_addr;
      w_wr_addr_d   = r_wr_addr;
      w_tx_data_d   = r_tx_data;
      w_tx_load_d   = 1'b0;
      w_wr_strobe_d = 1'b0;
      w_wr_en       = 1'b0;
      // CSn high aborts the frame and wins over a coincident received byte
      if (w_cs_n || w_cs_rise) begin
         w_state_d = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) w_state_d = ST_CMD;
            end
            ST_CMD: begin
               if (i_rx_done) begin
                  w_addr_d = i_rx_data[ADDR_W-1:0];
                  if (i_rx_data[CMD_RW_BIT]) begin
                     w_state_d   = ST_RD;
                     w_tx_load_d = 1'b1;
                     w_tx_data_d = rd_byte(i_rx_data[ADDR_W-1:0], o_regs);
                     w_addr_d    = i_rx_data[ADDR_W-1:0] + ADDR_STEP;
                  end else begin
                     w_state_d = ST_WR;
                  end
               end
            end
            ST_WR: begin
               if (i_rx_done) begin
                  if (r_addr != '0 && int'(r_addr) < NUM_REGS) begin
                     w_wr_en       = 1'b1;
                     w_wr_strobe_d = 1'b1;
                     w_wr_addr_d   = r_addr;
                  end
                  w_addr_d = r_addr + ADDR_STEP;
               end
            end
            ST_RD: begin
               if (i_rx_done) begin
                  w_tx_load_d = 1'b1;
                  w_tx_data_d = rd_byte(r_addr, o_regs);
                  w_addr_d    = r_addr + ADDR_STEP;
               end
            end
            default: w_state_d = ST_IDLE;
         endcase
      end
   end

   assign o_regs      = {r_regs, ID_VALUE};
   assign o_tx_load   = r_tx_load;
   assign o_tx_data   = r_tx_data;
   assign o_wr_strobe = r_wr_strobe;
   assign o_wr_addr   = r_wr_addr;
   assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a byte-level model pushes expected strobes/loads,
// a negedge monitor pops and compares them against the DUT pulses.
module tb_spi_reg_ctrl;

   localparam int unsigned NREGS = 8;
`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam logic [6:0] STEP = 7'd1;
`else
   localparam logic [6:0] STEP = 7'd0;
`endif

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cs_n = 1'b1;
   logic             rx_done = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             tx_load;
   logic [7:0]       tx_data;
   logic [8*NREGS-1:0] regs;
   logic             wr_strobe;
   logic [6:0]       wr_addr;
   logic             busy;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t wr_q[$];
   exp_t tx_q[$];

   logic [7:0] m_regs [NREGS];
   logic [6:0] m_addr = '0;
   int         mode   = 0;

   spi_reg_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_spi_cs_n  (cs_n),
      .i_rx_done   (rx_done),
      .i_rx_data   (rx_data),
      .o_tx_load   (tx_load),
      .o_tx_data   (tx_data),
      .o_regs      (regs),
      .o_wr_strobe (wr_strobe),
      .o_wr_addr   (wr_addr),
      .o_busy      (busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_rd(input logic [6:0] a);
      if (a == 7'd0)   return 8'hA5;
      if (a < 7'd8)    return m_regs[a[2:0]];
      return 8'hFF;
   endfunction

   function automatic logic [63:0] m_flat();
      logic [63:0] v;
      v[7:0] = 8'hA5;
      for (int i = 1; i < 8; i++) v[8*i +: 8] = m_regs[i];
      return v;
   endfunction

   // Expected pulses land on the edge after the one that captures rx_done
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      e.cyc = cyc + 1;
      case (mode)
         0: begin
            m_addr = b[6:0];
            if (b[7]) begin
               mode  = 2;
               e.val = m_rd(m_addr);
               tx_q.push_back(e);
               m_addr = m_addr + STEP;
            end else begin
               mode = 1;
            end
         end
         1: begin
            if (m_addr != 7'd0 && m_addr < 7'd8) begin
               m_regs[m_addr[2:0]] = b;
               e.val = {1'b0, m_addr};
               wr_q.push_back(e);
            end
            m_addr = m_addr + STEP;
         end
         default: begin
            e.val = m_rd(m_addr);
            tx_q.push_back(e);
            m_addr = m_addr + STEP;
         end
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_done = 1'b1;
      model_byte(b);
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      @(posedge clk);
   endtask

   task automatic start_frame();
      @(posedge clk);
      #1;
      cs_n = 1'b0;
      mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("busy_on", {63'b0, busy}, 64'd1);
   endtask

   task automatic end_frame();
      @(posedge clk);
      #1;
      cs_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("busy_off", {63'b0, busy}, 64'd0);
      check("regs", regs, m_flat());
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (wr_strobe) begin
            if (wr_q.size() == 0) begin
               check("wr_unexpected", 64'd1, 64'd0);
            end else begin
               e = wr_q.pop_front();
               check("wr_addr", {57'b0, wr_addr}, {56'b0, e.val});
               check("wr_latency", 64'(cyc), 64'(e.cyc));
            end
         end
         if (tx_load) begin
            if (tx_q.size() == 0) begin
               check("tx_unexpected", 64'd1, 64'd0);
            end else begin
               e = tx_q.pop_front();
               check("tx_data", {56'b0, tx_data}, {56'b0, e.val});
               check("tx_latency", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_tx_load", {63'b0, tx_load}, 64'd0);
      check("rst_tx_data", {56'b0, tx_data}, 64'd0);
      check("rst_wr_strobe", {63'b0, wr_strobe}, 64'd0);
      check("rst_wr_addr", {57'b0, wr_addr}, 64'd0);
      check("rst_regs", regs, m_flat());
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Writes: multi-byte, then a second register
      start_frame();
      send_byte(8'h01); send_byte(8'h3C); send_byte(8'h5A);
      end_frame();
      start_frame();
      send_byte(8'h02); send_byte(8'h5A);
      end_frame();

      // Reads: ID register, then register 1 with dummy bytes
      start_frame();
      send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
      end_frame();
      start_frame();
      send_byte(8'h81); send_byte(8'hFF);
      end_frame();

      // Ignored writes to ID and out-of-range addresses
      start_frame();
      send_byte(8'h00); send_byte(8'h11);
      end_frame();
      start_frame();
      send_byte(8'h08); send_byte(8'h22);
      end_frame();

      // Out-of-range and top-of-map reads
      start_frame();
      send_byte(8'h88); send_byte(8'h00);
      end_frame();
      start_frame();
      send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
      end_frame();
      start_frame();
      send_byte(8'h87); send_byte(8'h00);
      end_frame();

      // Address behaviour across a frame
      start_frame();
      send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
      end_frame();
      start_frame();
      send_byte(8'h83); send_byte(8'h00); send_byte(8'h00);
      end_frame();

      // CSn rises in the same cycle as a data byte in ST_WR
      start_frame();
      send_byte(8'h05);
      @(posedge clk);
      #1;
      cs_n = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rx_data = 8'h99;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      @(negedge clk);
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_regs", regs, m_flat());
      repeat (2) @(posedge clk);

      // Reset pulsed mid-frame
      start_frame();
      send_byte(8'h02); send_byte(8'h66);
      send_byte(8'h06);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
      check("midrst_busy", {63'b0, busy}, 64'd0);
      check("midrst_regs", regs, m_flat());
      check("midrst_tx_data", {56'b0, tx_data}, 64'd0);
      check("midrst_wr_addr", {57'b0, wr_addr}, 64'd0);
      cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      start_frame();
      send_byte(8'h07); send_byte(8'h42);
      end_frame();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("wr_q_empty", 64'(wr_q.size()), 64'd0);
      check("tx_q_empty", 64'(tx_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
